// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and a
// load/store port. Only one transaction is outstanding at a time: IDLE grants a
// requester, REQ presents the captured request to memory until it is accepted,
// and WAIT holds until the memory responds.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the
// requester not granted last; when undefined, the data port always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction fetch port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  // load/store port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  // shared memory port
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Owner of the outstanding transaction: 1 = data port, 0 = fetch port.
  logic                r_grant_data;

  // Registered memory request fields, stable for the whole REQ phase.
  logic                r_mem_req;
  logic                r_mem_wr;
  logic [3:0]          r_mem_wstrb;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;

  // Arbitration / handshake decode.
  logic                w_pick_data;
  logic                w_pick_inst;
  logic                w_grant_fire;
  logic                w_resp;

`ifdef ARB_ROUND_ROBIN_EN
  // Most recent grant: 1 = data port, 0 = fetch port. Starts at fetch so the
  // first tie after reset goes to data.
  logic                r_last_data;
`endif

  // Choose which requester would be granted if the FSM is in IDLE.
  always_comb begin
    w_pick_data = 1'b0;
    w_pick_inst = 1'b0;
    if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (r_last_data) begin
        w_pick_inst = 1'b1;
      end else begin
        w_pick_data = 1'b1;
      end
`else
      w_pick_data = 1'b1;
`endif
    end else if (data_req) begin
      w_pick_data = 1'b1;
    end else if (inst_req) begin
      w_pick_inst = 1'b1;
    end else begin
      w_pick_data = 1'b0;
      w_pick_inst = 1'b0;
    end
  end

  // Next-state and handshake decode for the IDLE/REQ/WAIT controller.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_fire = 1'b0;
    w_resp       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_data || w_pick_inst) begin
          w_grant_fire = 1'b1;
          w_state_nxt  = ST_REQ;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            // Memory accepted and answered in the same cycle.
            w_resp      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_data_ok) begin
          w_resp      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Record the owner of each new transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant_data <= 1'b1;
    end else if (w_grant_fire) begin
      r_grant_data <= w_pick_data;
    end else begin
      r_grant_data <= r_grant_data;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Track the last granted port so the next tie alternates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_data <= 1'b0;
    end else if (w_grant_fire) begin
      r_last_data <= w_pick_data;
    end else begin
      r_last_data <= r_last_data;
    end
  end
`endif

  // Capture the granted request into the memory-side registers and drop
  // mem_req once the memory has accepted it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wstrb <= 4'h0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= 32'h0000_0000;
    end else if (w_grant_fire) begin
      r_mem_req <= 1'b1;
      if (w_pick_data) begin
        r_mem_wr    <= data_wr;
        // Byte enables are meaningless for loads; present zero.
        r_mem_wstrb <= data_wr ? data_wstrb : 4'h0;
        r_mem_addr  <= data_addr;
        r_mem_wdata <= data_wdata;
      end else begin
        r_mem_wr    <= 1'b0;
        r_mem_wstrb <= 4'h0;
        r_mem_addr  <= inst_addr;
        r_mem_wdata <= 32'h0000_0000;
      end
    end else if ((r_state == ST_REQ) && mem_addr_ok) begin
      r_mem_req   <= 1'b0;
      r_mem_wr    <= r_mem_wr;
      r_mem_wstrb <= r_mem_wstrb;
      r_mem_addr  <= r_mem_addr;
      r_mem_wdata <= r_mem_wdata;
    end else begin
      r_mem_req   <= r_mem_req;
      r_mem_wr    <= r_mem_wr;
      r_mem_wstrb <= r_mem_wstrb;
      r_mem_addr  <= r_mem_addr;
      r_mem_wdata <= r_mem_wdata;
    end
  end

  // Handshakes back to the requesters; all are held low while in reset.
  assign inst_addr_ok = resetn & w_grant_fire & w_pick_inst;
  assign data_addr_ok = resetn & w_grant_fire & w_pick_data;
  assign inst_data_ok = resetn & w_resp & ~r_grant_data;
  assign data_data_ok = resetn & w_resp &  r_grant_data;

  // Read data is a straight pass-through; only data_ok qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign mem_req   = r_mem_req;
  assign mem_wr    = r_mem_wr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width of all address ports.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port inst_req  input  1  fetch read request, held until inst_addr_ok.
REQ-005 The block SHALL have port inst_addr  input  ADDR_W  fetch byte address.
REQ-006 The block SHALL have port inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-007 The block SHALL have port inst_data_ok  output  1  fetch read data valid this cycle.
REQ-008 The block SHALL have port inst_rdata  output  32  fetch read data.
REQ-009 The block SHALL have port data_req  input  1  load/store request, held until data_addr_ok.
REQ-010 The block SHALL have port data_wr  input  1  1 = store, 0 = load.
REQ-011 The block SHALL have port data_wstrb  input  4  store byte enables.
REQ-012 The block SHALL have port data_addr  input  ADDR_W  load/store byte address.
REQ-013 The block SHALL have port data_wdata  input  32  store data.
REQ-014 The block SHALL have port data_addr_ok  output  1  data request accepted this cycle.
REQ-015 The block SHALL have port data_data_ok  output  1  load data valid or store done this cycle.
REQ-016 The block SHALL have port data_rdata  output  32  load data.
REQ-017 The block SHALL have port mem_req  output  1  shared memory request.
REQ-018 The block SHALL have port mem_wr  output  1  shared memory write flag.
REQ-019 The block SHALL have port mem_wstrb  output  4  shared memory byte enables; 0 for reads.
REQ-020 The block SHALL have port mem_addr  output  ADDR_W  shared memory address.
REQ-021 The block SHALL have port mem_wdata  output  32  shared memory write data.
REQ-022 The block SHALL have port mem_addr_ok  input  1  memory accepted mem_req.
REQ-023 The block SHALL have port mem_data_ok  input  1  memory response valid.
REQ-024 The block SHALL have port mem_rdata  input  32  memory read data.

Function
REQ-025 The block SHALL implement FSM states IDLE, REQ and WAIT, with one transaction outstanding at most.
REQ-026 IDLE: if any request is present, the block SHALL grant one requester, assert its addr_ok combinationally that cycle, register wr/wstrb/addr/wdata into mem_* and enter REQ.
REQ-027 Inst grants SHALL register mem_wr=0 and mem_wstrb=0.
REQ-028 Tie (both requesting) without round-robin: data SHALL win and inst stays pending.
REQ-029 REQ: mem_req SHALL be 1 with mem_* stable until mem_addr_ok; then go to WAIT, or to IDLE if mem_data_ok is also 1 that cycle.
REQ-030 WAIT: on mem_data_ok, the granted port's data_ok SHALL pulse for exactly that cycle with rdata = mem_rdata (combinational pass-through); then go to IDLE.
REQ-031 Non-granted data_ok SHALL stay 0; mem_data_ok in IDLE SHALL be ignored.
REQ-032 addr_ok SHALL never assert outside IDLE, so new requests wait without loss.
REQ-033 Minimum latency: accept at cycle T, mem_req at T+1, data_ok no earlier than T+1; back-to-back grant no earlier than data_ok cycle +1.
REQ-034 inst_rdata and data_rdata SHALL both be driven by mem_rdata; only data_ok qualifies them.

Reset
REQ-035 resetn=0 SHALL asynchronously force IDLE, mem_req/mem_wr=0, mem_wstrb/mem_addr/mem_wdata=0, grant=data, last_grant=inst; all addr_ok/data_ok are 0 while in reset.
REQ-036 Reset mid-transaction SHALL abandon it without any data_ok; the memory is reset together with this block.

Configuration
REQ-037 With ARB_ROUND_ROBIN_EN defined, a tie SHALL go to the requester not granted last (last_grant updated on every grant; the first tie after reset goes to data); without it, fixed data priority per REQ-028.

Verification
REQ-038 Inst only, inst_addr=0x1C000000, mem_addr_ok at T+1, mem_data_ok at T+3 with rdata 0x02800404 -> inst_data_ok at T+3, inst_rdata=0x02800404.
REQ-039 Data store, addr=0x00000100, wstrb=0x3, wdata=0xA5A5 -> mem_wr=1, mem_wstrb=0x3, data_data_ok pulses once; inst_data_ok stays 0.
REQ-040 Both requesting continuously for 4 transactions -> without macro all 4 grants go to data; with ARB_ROUND_ROBIN_EN grants go data, inst, data, inst.
REQ-041 mem_addr_ok and mem_data_ok both 1 in first REQ cycle -> data_ok same cycle, IDLE next; mem_addr_ok held 0 for 5 cycles -> mem_req and mem_addr held stable.
REQ-042 resetn low during WAIT, then mem_data_ok=1 after release -> no data_ok; next inst request completes normally.
